status_7seg_mux: RTL and testbench

STATUS_7SEG_MUX -- requirements
Module: status_7seg_mux

---
 rtl/status_7seg_pkg.sv | 42 ++++
 rtl/status_7seg_mux_glyph_rom.sv | 11 +
 rtl/status_7seg_mux.sv | 129 ++++++++++++
 tb/tb_status_7seg_mux.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/status_7seg_pkg.sv
// Shared status codes and the active-high abcdefg glyph table for the
// status display multiplexer.
package status_7seg_pkg;

    typedef logic [3:0] status_code_t;
    typedef logic [6:0] glyph_t;

    localparam status_code_t CODE_NADA   = 4'd0;
    localparam status_code_t CODE_ALARMA = 4'd1;
    localparam status_code_t CODE_CARGA  = 4'd2;
    localparam status_code_t CODE_ERROR  = 4'd3;
    localparam status_code_t CODE_VOLT   = 4'd4;
    localparam status_code_t CODE_PAUSA  = 4'd5;
    localparam status_code_t CODE_HOLD   = 4'd6;
    localparam status_code_t CODE_LISTO  = 4'd7;
    localparam status_code_t CODE_BLANK  = 4'd15;

    // Bit 6 is segment a, bit 0 is segment g; 1 = lit.
    localparam glyph_t GLYPH_TABLE [16] = '{
        7'b0011101,  // o
        7'b1110111,  // A
        7'b1001110,  // C
        7'b1001111,  // E
        7'b0111110,  // V
        7'b1100111,  // P
        7'b0110111,  // H
        7'b0001110,  // L
        7'b0000000,
        7'b0000000,
        7'b0000000,
        7'b0000000,
        7'b0000000,
        7'b0000000,
        7'b0000000,
        7'b0000000
    };

    function automatic glyph_t glyph_of(input status_code_t code);
        return GLYPH_TABLE[code];
    endfunction

endpackage

// File: rtl/status_7seg_mux_glyph_rom.sv
// Combinational status code to active-high glyph decoder.
module seg_glyph_rom
    import status_7seg_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] glyph_o
);

    assign glyph_o = glyph_of(code_i);

endmodule

// File: rtl/status_7seg_mux.sv
// Time-multiplexed 7-segment status display: shadow-registered codes, a blank
// slot at the start of each digit to avoid ghosting, and per-digit blinking.
module status_7seg_mux
    import status_7seg_pkg::*;
#(
    parameter int NDIG           = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_DIV      = 25,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*NDIG-1:0]     estado,
    input  logic [NDIG-1:0]       blink_en,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic [NDIG-1:0]       an
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0]   SCAN_TC  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]   IDX_LAST = IW'(NDIG - 1);
    localparam logic [FW-1:0]   FRAME_TC = FW'(BLINK_DIV - 1);
    localparam logic [6:0]      SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic [NDIG-1:0] AN_OFF   = {NDIG{AN_ACTIVE_LOW}};

    logic [CW-1:0]     scan_q, scan_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic              phase_q, phase_d;
    logic [4*NDIG-1:0] codes_q, codes_d;
    logic [NDIG-1:0]   blink_q, blink_d;
    logic [6:0]        seg_q, seg_d;
    logic [NDIG-1:0]   an_q, an_d;

    logic              scan_tc;
    logic              idx_wrap;
    logic [3:0]        cur_code;
    logic              cur_blink;
    logic [NDIG-1:0]   an_sel;
    logic [6:0]        glyph;

    assign scan_tc  = (scan_q == SCAN_TC);
    assign idx_wrap = scan_tc && (idx_q == IDX_LAST);

    always_comb begin
        scan_d  = scan_tc ? '0 : scan_q + 1'b1;
        idx_d   = idx_q;
        frame_d = frame_q;
        phase_d = phase_q;
        if (scan_tc) begin
            idx_d = idx_wrap ? '0 : idx_q + 1'b1;
        end
        if (idx_wrap) begin
            if (frame_q == FRAME_TC) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    always_comb begin
        codes_d = load ? estado   : codes_q;
        blink_d = load ? blink_en : blink_q;
    end

    always_comb begin
        cur_code  = CODE_BLANK;
        cur_blink = 1'b0;
        an_sel    = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IW'(i)) begin
                cur_code  = codes_q[4*i +: 4];
                cur_blink = blink_q[i];
                an_sel[i] = 1'b1;
            end
        end
    end

    seg_glyph_rom u_rom (
        .code_i  (cur_code),
        .glyph_o (glyph)
    );

    // Outputs are registered from the current counter/index/shadow, so the
    // slot at scan_q == 0 always produces one fully dark cycle.
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if (scan_q != '0) begin
            an_d = an_sel ^ AN_OFF;
            if (!(phase_q && cur_blink)) begin
                seg_d = glyph ^ SEG_OFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_q  <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
            codes_q <= {NDIG{CODE_BLANK}};
            blink_q <= '0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
        end else begin
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
            codes_q <= codes_d;
            blink_q <= blink_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_status_7seg_mux.sv
// Directed bench for status_7seg_mux with NDIG=4, SCAN_DIV=4, BLINK_DIV=2, active-low outputs.
module tb_status_7seg_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] estado;
    logic [3:0]  blink_en;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int passed = 0;
    int s;

    logic [6:0]  gl_al [16];
    logic [15:0] m_codes;
    logic [3:0]  m_blink;

    always #5 clk = ~clk;

    status_7seg_mux #(
        .NDIG(4), .SCAN_DIV(4), .BLINK_DIV(2),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .estado   (estado),
        .blink_en (blink_en),
        .load     (load),
        .seg      (seg),
        .an       (an)
    );

    // s counts output cycles since reset release: s=0 is the first dark cycle,
    // each digit owns 4 cycles, a frame is 16 cycles, blink phase flips every 32.
    function automatic logic [6:0] exp_seg(input int ss, input logic [15:0] c, input logic [3:0] b);
        int cnt = ss % 4;
        int dig = (ss / 4) % 4;
        int ph  = (ss / 32) % 2;
        if (cnt == 0) return 7'h7F;
        if (ph == 1 && b[dig]) return 7'h7F;
        return gl_al[c[dig*4 +: 4]];
    endfunction

    function automatic logic [3:0] exp_an(input int ss);
        logic [3:0] one = 4'b0001;
        int cnt = ss % 4;
        int dig = (ss / 4) % 4;
        if (cnt == 0) return 4'hF;
        return ~(one << dig);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        s++;
    endtask

    task automatic reset_and_load(input logic [15:0] c, input logic [3:0] b);
        reset = 1'b1;
        load  = 1'b0;
        tick;
        tick;
        reset    = 1'b0;
        load     = 1'b1;
        estado   = c;
        blink_en = b;
        s = -1;
        tick;
        load    = 1'b0;
        m_codes = c;
        m_blink = b;
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        load     = 1'b1;
        estado   = 16'h1111;
        blink_en = 4'hF;
        for (int k = 0; k < 2; k++) begin
            tick;
            checks++;
            if (seg !== 7'h7F) $display("FAIL reset_seg cyc=%0d got=%b exp=%b", k, seg, 7'h7F);
            else passed++;
            checks++;
            if (an !== 4'hF) $display("FAIL reset_an cyc=%0d got=%b exp=%b", k, an, 4'hF);
            else passed++;
        end
        reset = 1'b0;
        load  = 1'b0;
        s = -1;
        for (int k = 0; k < 64; k++) begin
            tick;
            checks++;
            if (seg !== 7'h7F) $display("FAIL idle_seg s=%0d got=%b exp=%b", s, seg, 7'h7F);
            else passed++;
            checks++;
            if (an !== exp_an(s)) $display("FAIL idle_an s=%0d got=%b exp=%b", s, an, exp_an(s));
            else passed++;
        end
    endtask

    task automatic test_glyphs(input logic [15:0] c);
        reset_and_load(c, 4'h0);
        for (int k = 0; k < 64; k++) begin
            tick;
            checks++;
            if (seg !== exp_seg(s, m_codes, m_blink))
                $display("FAIL glyph_seg codes=%h s=%0d got=%b exp=%b", c, s, seg, exp_seg(s, m_codes, m_blink));
            else passed++;
            checks++;
            if (an !== exp_an(s)) $display("FAIL glyph_an codes=%h s=%0d got=%b exp=%b", c, s, an, exp_an(s));
            else passed++;
        end
    endtask

    task automatic test_blink;
        reset_and_load(16'h0003, 4'b0001);
        for (int k = 0; k < 128; k++) begin
            tick;
            checks++;
            if (seg !== exp_seg(s, m_codes, m_blink))
                $display("FAIL blink_seg s=%0d got=%b exp=%b", s, seg, exp_seg(s, m_codes, m_blink));
            else passed++;
            checks++;
            if (an !== exp_an(s)) $display("FAIL blink_an s=%0d got=%b exp=%b", s, an, exp_an(s));
            else passed++;
        end
        // Hand-checked anchors: lit 'E' in frame 0, dark but enabled in frame 2.
        s = s;
    endtask

    task automatic test_load_on_advance;
        reset_and_load(16'h4321, 4'h0);
        for (int k = 0; k < 6; k++) tick;
        // Next edge has scan counter at terminal count (digit 1 -> 2).
        load   = 1'b1;
        estado = 16'h7654;
        tick;
        load = 1'b0;
        checks++;
        if (seg !== 7'b0110001) $display("FAIL adv_old_glyph s=%0d got=%b exp=%b", s, seg, 7'b0110001);
        else passed++;
        m_codes = 16'h7654;
        tick;
        checks++;
        if (seg !== 7'h7F || an !== 4'hF) $display("FAIL adv_blank s=%0d got=%b/%b exp=%b/%b", s, seg, an, 7'h7F, 4'hF);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if (seg !== 7'b1001000 || an !== 4'b1011)
                $display("FAIL adv_new_glyph s=%0d got=%b/%b exp=%b/%b", s, seg, an, 7'b1001000, 4'b1011);
            else passed++;
        end
        for (int k = 0; k < 20; k++) begin
            tick;
            checks++;
            if (seg !== exp_seg(s, m_codes, m_blink) || an !== exp_an(s))
                $display("FAIL adv_follow s=%0d got=%b/%b exp=%b/%b", s, seg, an, exp_seg(s, m_codes, m_blink), exp_an(s));
            else passed++;
        end
    endtask

    task automatic test_reset_mid;
        reset_and_load(16'h4321, 4'h0);
        for (int k = 0; k < 10; k++) tick;
        checks++;
        if (seg !== 7'b0110000 || an !== 4'b1011)
            $display("FAIL mid_pre s=%0d got=%b/%b exp=%b/%b", s, seg, an, 7'b0110000, 4'b1011);
        else passed++;
        reset = 1'b1;
        tick;
        checks++;
        if (seg !== 7'h7F || an !== 4'hF) $display("FAIL mid_reset got=%b/%b exp=%b/%b", seg, an, 7'h7F, 4'hF);
        else passed++;
        reset   = 1'b0;
        m_codes = 16'hFFFF;
        m_blink = 4'h0;
        s = -1;
        tick;
        checks++;
        if (seg !== 7'h7F || an !== 4'hF) $display("FAIL mid_first_blank got=%b/%b exp=%b/%b", seg, an, 7'h7F, 4'hF);
        else passed++;
        tick;
        checks++;
        if (seg !== 7'h7F || an !== 4'b1110) $display("FAIL mid_first_lit got=%b/%b exp=%b/%b", seg, an, 7'h7F, 4'b1110);
        else passed++;
        for (int k = 0; k < 14; k++) begin
            tick;
            checks++;
            if (seg !== exp_seg(s, m_codes, m_blink) || an !== exp_an(s))
                $display("FAIL mid_follow s=%0d got=%b/%b exp=%b/%b", s, seg, an, exp_seg(s, m_codes, m_blink), exp_an(s));
            else passed++;
        end
    endtask

    task automatic test_blank_codes(input logic [15:0] c);
        reset_and_load(c, 4'h0);
        for (int k = 0; k < 64; k++) begin
            tick;
            checks++;
            if (seg !== 7'h7F) $display("FAIL blank_seg codes=%h s=%0d got=%b exp=%b", c, s, seg, 7'h7F);
            else passed++;
            checks++;
            if (an !== exp_an(s)) $display("FAIL blank_an codes=%h s=%0d got=%b exp=%b", c, s, an, exp_an(s));
            else passed++;
        end
    endtask

    initial begin
        gl_al[0]  = 7'b1100010;
        gl_al[1]  = 7'b0001000;
        gl_al[2]  = 7'b0110001;
        gl_al[3]  = 7'b0110000;
        gl_al[4]  = 7'b1000001;
        gl_al[5]  = 7'b0011000;
        gl_al[6]  = 7'b1001000;
        gl_al[7]  = 7'b1110001;
        for (int i = 8; i < 16; i++) gl_al[i] = 7'h7F;
        reset    = 1'b1;
        load     = 1'b0;
        estado   = 16'h0000;
        blink_en = 4'h0;
        s        = 0;

        test_reset;
        test_glyphs(16'h4321);
        test_glyphs(16'h7650);
        test_blink;
        test_load_on_advance;
        test_reset_mid;
        test_blank_codes(16'hBA98);
        test_blank_codes(16'hFEDC);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
